// File: rtl/mul_pkg.sv
// Shared types and width helpers for the floating-point multiplier datapath.
// Widths are functions of the fraction width so every stage derives them consistently.
package mul_pkg;

  localparam int DEF_EXPO_W = 8;
  localparam int DEF_MANT_W = 23;
  localparam int DEF_ZERO_D = 6;

  function automatic int pw_f(input int mant_w);
    return 2 * mant_w + 2;
  endfunction

  function automatic int sat_f(input int mant_w);
    return 2 * mant_w + 1;
  endfunction

  localparam int PW  = pw_f(DEF_MANT_W);
  localparam int SAT = sat_f(DEF_MANT_W);

  typedef enum logic {
    LEFT,
    RIGHT
  } mode_e;

  // Stage payload at the default widths.
  typedef struct packed {
    mode_e                 mode;
    logic [DEF_EXPO_W+1:0] expo;
    logic [PW-1:0]         mant;
    logic                  sticky;
    logic                  zero;
  } stage_t;

endpackage

// File: rtl/mul_norm_shift_if.sv
// Valid/ready bundle between the multiplier shift-amount logic, this stage and the rounder.
// The slave view belongs to the normalization stage; the master view to its environment.
interface mul_norm_shift_if
  import mul_pkg::*;
#(
  parameter int EXPO_W = DEF_EXPO_W,
  parameter int MANT_W = DEF_MANT_W,
  parameter int ZERO_D = DEF_ZERO_D
);
  localparam int PROD_W = pw_f(MANT_W);

  logic                in_valid;
  logic                in_ready;
  logic [EXPO_W+1:0]   expo_1;
  logic [PROD_W-1:0]   mant_prod;
  logic [ZERO_D:0]     r_shift;
  logic [ZERO_D:0]     l_shift;

  logic                out_valid;
  logic                out_ready;
  logic [MANT_W:0]     out_mant;
  logic                out_guard;
  logic                out_sticky;
  logic [EXPO_W+1:0]   out_expo;
  logic                out_zero;

  modport master (
    output in_valid, expo_1, mant_prod, r_shift, l_shift, out_ready,
    input  in_ready, out_valid, out_mant, out_guard, out_sticky, out_expo, out_zero
  );

  modport slave (
    input  in_valid, expo_1, mant_prod, r_shift, l_shift, out_ready,
    output in_ready, out_valid, out_mant, out_guard, out_sticky, out_expo, out_zero
  );

endinterface

// File: rtl/mul_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module mul_lzc #(
  parameter int W  = 48,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) begin
        cnt = CW'(W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/mul_norm_shift.sv
// Normalization stage of the FP multiplier: left-normalizes normal products or
// right-denormalizes tiny ones, in a three-register valid/ready pipeline.
module mul_norm_shift
  import mul_pkg::*;
#(
  parameter int EXPO_W = DEF_EXPO_W,
  parameter int MANT_W = DEF_MANT_W,
  parameter int ZERO_D = DEF_ZERO_D
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_norm_shift_if.slave bus
);

  localparam int PROD_W = pw_f(MANT_W);
  localparam int EW     = EXPO_W + 2;
  localparam int SW     = ZERO_D + 1;
  localparam int CW     = $clog2(PROD_W + 1);
  localparam int AW     = ((SW > CW) ? SW : CW) + 1;

  typedef struct packed {
    mode_e              mode;
    logic [EW-1:0]      expo;
    logic [PROD_W-1:0]  mant;
    logic               sticky;
    logic               zero;
  } pipe_t;

  // ---------------- handshake chain ----------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic out_valid_q, out_valid_d;
  logic s3_free, s2_free, s1_free;

  assign s3_free = !out_valid_q || bus.out_ready;
  assign s2_free = !s2_valid_q || s3_free;
  assign s1_free = !s1_valid_q || s2_free;

  assign bus.in_ready = s1_free;

  // ---------------- stage 1: capture, lzc, mode ----------------
  logic [CW-1:0]     in_lzc;
  logic              in_left;

  mode_e             s1_mode_q, s1_mode_d;
  logic [EW-1:0]     s1_expo_q, s1_expo_d;
  logic [PROD_W-1:0] s1_mant_q, s1_mant_d;
  logic [CW-1:0]     s1_lzc_q, s1_lzc_d;
  logic [SW-1:0]     s1_rsh_q, s1_rsh_d;
  logic [SW-1:0]     s1_lsh_q, s1_lsh_d;

  mul_lzc #(
    .W  (PROD_W),
    .CW (CW)
  ) u_lzc (
    .din (bus.mant_prod),
    .cnt (in_lzc)
  );

  // Signed expo_1 >= 1: sign clear and not zero.
  assign in_left = !bus.expo_1[EW-1] && (bus.expo_1 != '0);

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_expo_d  = s1_expo_q;
    s1_mant_d  = s1_mant_q;
    s1_lzc_d   = s1_lzc_q;
    s1_rsh_d   = s1_rsh_q;
    s1_lsh_d   = s1_lsh_q;
    if (s1_free) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_mode_d = in_left ? LEFT : RIGHT;
        s1_expo_d = bus.expo_1;
        s1_mant_d = bus.mant_prod;
        s1_lzc_d  = in_lzc;
        s1_rsh_d  = bus.r_shift;
        s1_lsh_d  = bus.l_shift;
      end
    end
  end

  // ---------------- stage 2: shift and right-shift loss ----------------
  pipe_t             s2_q, s2_d;
  logic [AW-1:0]     lzc_ext, rsh_ext, s_amt;
  logic [PROD_W-1:0] left_p, right_p, right_mask;
  logic              right_loss;

  always_comb begin
    lzc_ext    = AW'(s1_lzc_q);
    rsh_ext    = AW'(s1_rsh_q);
    s_amt      = (lzc_ext < rsh_ext) ? lzc_ext : rsh_ext;
    left_p     = s1_mant_q << s_amt;
    right_p    = s1_mant_q >> s1_lsh_q;
    right_mask = ~({PROD_W{1'b1}} << s1_lsh_q);
    right_loss = |(s1_mant_q & right_mask);
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d.mode = s1_mode_q;
        s2_d.zero = (s1_mant_q == '0);
        if (s1_mode_q == LEFT) begin
          s2_d.mant   = left_p;
          s2_d.expo   = s1_expo_q - EW'(s_amt);
          s2_d.sticky = 1'b0;
        end else begin
          s2_d.mant   = right_p;
          s2_d.expo   = s1_expo_q;
          s2_d.sticky = right_loss;
        end
      end
    end
  end

  // ---------------- stage 3: output register ----------------
  logic [MANT_W:0] out_mant_q, out_mant_d;
  logic            out_guard_q, out_guard_d;
  logic            out_sticky_q, out_sticky_d;
  logic [EW-1:0]   out_expo_q, out_expo_d;
  logic            out_zero_q, out_zero_d;

  logic [MANT_W:0] fin_mant;
  logic [EW-1:0]   fin_eff;

  always_comb begin
    fin_mant = s2_q.mant[PROD_W-1:MANT_W+1];
    // Denormalized results always carry the minimum normal exponent.
    fin_eff  = (s2_q.mode == RIGHT) ? EW'(1) : s2_q.expo;
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_mant_d   = out_mant_q;
    out_guard_d  = out_guard_q;
    out_sticky_d = out_sticky_q;
    out_expo_d   = out_expo_q;
    out_zero_d   = out_zero_q;
    if (s3_free) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        if (s2_q.zero) begin
          out_mant_d   = '0;
          out_guard_d  = 1'b0;
          out_sticky_d = 1'b0;
          out_expo_d   = '0;
          out_zero_d   = 1'b1;
        end else begin
          out_mant_d   = fin_mant;
          out_guard_d  = s2_q.mant[MANT_W];
          out_sticky_d = (|s2_q.mant[MANT_W-1:0]) | s2_q.sticky;
          out_expo_d   = fin_mant[MANT_W] ? fin_eff : '0;
          out_zero_d   = 1'b0;
        end
      end
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= LEFT;
      s1_expo_q    <= '0;
      s1_mant_q    <= '0;
      s1_lzc_q     <= '0;
      s1_rsh_q     <= '0;
      s1_lsh_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_q         <= '0;
      out_valid_q  <= 1'b0;
      out_mant_q   <= '0;
      out_guard_q  <= 1'b0;
      out_sticky_q <= 1'b0;
      out_expo_q   <= '0;
      out_zero_q   <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_mode_q    <= s1_mode_d;
      s1_expo_q    <= s1_expo_d;
      s1_mant_q    <= s1_mant_d;
      s1_lzc_q     <= s1_lzc_d;
      s1_rsh_q     <= s1_rsh_d;
      s1_lsh_q     <= s1_lsh_d;
      s2_valid_q   <= s2_valid_d;
      s2_q         <= s2_d;
      out_valid_q  <= out_valid_d;
      out_mant_q   <= out_mant_d;
      out_guard_q  <= out_guard_d;
      out_sticky_q <= out_sticky_d;
      out_expo_q   <= out_expo_d;
      out_zero_q   <= out_zero_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_mant   = out_mant_q;
  assign bus.out_guard  = out_guard_q;
  assign bus.out_sticky = out_sticky_q;
  assign bus.out_expo   = out_expo_q;
  assign bus.out_zero   = out_zero_q;

endmodule

// File: doc/mul_norm_shift.md
# mul_norm_shift

Normalization stage of the floating-point multiplier datapath. It takes the raw significand product, its pre-normalization exponent, and the saturated shift amounts produced by the multiplier's shift-amount logic. It left-normalizes normal results or right-denormalizes tiny results, and outputs an (M+1)-bit significand with guard/sticky and final exponent to the rounder. It is a 3-stage valid/ready pipeline with full backpressure.

## Interface
- EXPO_W, 8, exponent field width
- MANT_W, 23, fraction width (M); product width PW = 2*MANT_W+2
- ZERO_D, 6, shift-amount MSB index; shift ports are ZERO_D+1 bits
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept
- expo_1  in  EXPO_W+2  signed exponent of product with leading position at bit PW-1
- mant_prod  in  PW  unsigned significand product
- r_shift  in  ZERO_D+1  max left shift, = expo_1-1, saturated to 2*MANT_W+1
- l_shift  in  ZERO_D+1  right shift, = 1-expo_1, saturated to 2*MANT_W+1
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_mant  out  MANT_W+1  hidden bit + fraction
- out_guard  out  1  first bit below out_mant LSB
- out_sticky  out  1  OR of all lower/shifted-out bits
- out_expo  out  EXPO_W+2  final exponent, 0 = subnormal encoding
- out_zero  out  1  mant_prod was zero

## Operation
- Mode select on signed expo_1: expo_1 >= 1 → LEFT; expo_1 <= 0 → RIGHT.
- LEFT: s = min(lzc(mant_prod), r_shift); P' = mant_prod << s; e_eff = expo_1 - s.
- RIGHT: P' = mant_prod >> l_shift, with shifted-out bits ORed into sticky; e_eff = 1.
- Saturated amount 2*MANT_W+1 (47 at defaults) moves every nonzero bit into sticky.
- out_mant = P'[PW-1:MANT_W+1]; out_guard = P'[MANT_W]; out_sticky = |P'[MANT_W-1:0] | right-shift loss.
- out_expo = out_mant[MANT_W] ? e_eff : 0.
- mant_prod == 0: out_zero=1, mant/guard/sticky/expo all 0, regardless of mode.
- No overflow detection here. out_expo passes through at full width; the rounder checks overflow.
- r_shift/l_shift are trusted to match expo_1 and are not recomputed.

## Timing
- Stages: S1 captures inputs and computes lzc/mode. S2 computes s, shifts, and gathers sticky. S3 is the output register.
- Latency: 3 cycles from accepted in_valid&&in_ready to out_valid, with no stall.
- Throughput: 1 per cycle when out_ready=1.
- Stage k advances when its next stage is empty or advancing. S3 advances on !out_valid || out_ready.
- in_ready = !s1_valid || s1_advance. in_ready is combinational from out_ready through the stage chain.
- Held output is stable while out_valid && !out_ready. No drop, duplication, or reorder.
- Accept and output-drain in the same cycle when full: both proceed.
- Reset: all stage valids = 0, out_valid=0, out_mant/out_guard/out_sticky/out_expo/out_zero = 0. in_ready = 1 after reset.
- rst_n assertion mid-flight discards all in-flight transactions immediately.

## Structure
- Shared package mul_pkg holds:
  - PW and SAT = 2*MANT_W+1 as localparam functions of the parameters
  - a stage struct typedef {mode, expo, mant, sticky, zero}
  - the mode enum {LEFT, RIGHT}
- One sub-module, mul_lzc: parameterised PW-bit leading-zero counter, combinational, used in S1.
- Stage registers are per-stage valid flops plus data flops with enable; no FSM beyond the valid chain.

## Test plan
All values use default parameters.
- Already normal: mant_prod=48'h8000_0000_0000, expo_1=100, r_shift=99 → 3 cycles later out_mant=24'h800000, guard=0, sticky=0, out_expo=100.
- Left by 1 with sticky: mant_prod=48'h4000_0000_0001, expo_1=100, r_shift=99 → out_mant=24'h800000, guard=0, sticky=1, out_expo=99.
- Left capped: mant_prod=48'h2000_0000_0000, expo_1=2, r_shift=1 → out_mant=24'h400000, out_expo=0.
- Right denormalize: mant_prod=48'h8000_0000_0000, expo_1=10'h3FD (-3), l_shift=4 → out_mant=24'h080000, sticky=0, out_expo=0.
- Saturated right shift: expo_1=-100, l_shift=47, mant_prod=48'hC000_0000_0000 → out_mant=0, guard=0, sticky=1, out_zero=0.
  - Same case with mant_prod=0 → out_zero=1 and all other outputs 0.
- Backpressure: 5 back-to-back inputs with out_ready=0 for 6 cycles → in_ready=0 after 3 accepts.
  - Release out_ready → 5 results in order, each held stable while stalled.
  - Then pulse rst_n low with 2 in flight → out_valid=0 next edge and no stale result after release.
